// File: rtl/reg_file_32x32_pkg.sv
// Shared sizing and types for the MIPS general-purpose register file.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;
endpackage

// File: rtl/reg_file_32x32_wr_decoder.sv
// Write-address decoder: turns we/wa into a one-hot per-register enable.
// Register 0 never gets an enable, so it can never be written.
module reg_wr_decoder
  import regfile_pkg::*;
(
  input  logic                we,
  input  reg_addr_t           wa,
  output logic [NUM_REGS-1:0] en
);

  always_comb begin
    en = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      en[i] = we & (wa == reg_addr_t'(i));
    end
  end

endmodule

// File: rtl/reg_file_32x32.sv
// 32x32 register file: one synchronous write port, two combinational read ports.
// Define REG_FILE_WR_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_32x32
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  reg_addr_t wa,
  input  reg_data_t wd,
  input  reg_addr_t ra1,
  input  reg_addr_t ra2,
  output reg_data_t rd1,
  output reg_data_t rd2
);

  logic [NUM_REGS-1:0] en;
  reg_data_t           regs_q [NUM_REGS];
  reg_data_t           regs_d [NUM_REGS];

  reg_wr_decoder u_wr_decoder (
    .we (we),
    .wa (wa),
    .en (en)
  );

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = en[i] ? wd : regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef REG_FILE_WR_BYPASS_EN
  // Forwarding is gated by rst_n so the ports still read zero during reset.
  logic fwd1;
  logic fwd2;

  assign fwd1 = rst_n & we & (wa != REG_ZERO) & (ra1 == wa);
  assign fwd2 = rst_n & we & (wa != REG_ZERO) & (ra2 == wa);

  always_comb begin
    rd1 = (ra1 == REG_ZERO) ? '0 : (fwd1 ? wd : regs_q[ra1]);
    rd2 = (ra2 == REG_ZERO) ? '0 : (fwd2 ? wd : regs_q[ra2]);
  end
`else
  always_comb begin
    rd1 = (ra1 == REG_ZERO) ? '0 : regs_q[ra1];
    rd2 = (ra2 == REG_ZERO) ? '0 : regs_q[ra2];
  end
`endif

endmodule

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench for reg_file_32x32: directed cases plus random traffic
// against an array-based reference model.
module tb_reg_file_32x32;

`ifdef REG_FILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  logic [31:0] model [32];
  int checks;
  int errors;

  reg_file_32x32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value from the architectural rules, not the RTL structure.
  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (!rst_n || ra == 5'd0) return 32'd0;
    if (BYP && we && wa != 5'd0 && ra == wa) return wd;
    return model[ra];
  endfunction

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n && we && wa != 5'd0) model[wa] = wd;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      chk({tag, "_rd1"}, rd1, exp_rd(ra1));
      chk({tag, "_rd2"}, rd2, exp_rd(ra2));
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    clear_model();
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd5; ra2 = 5'd31;
    #2;
    chk("por_rd1", rd1, 32'd0);
    chk("por_rd2", rd2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. reset mid-cycle clears immediately
    drive(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5);
    step();
    chk("r5_written", rd1, 32'h12345678);
    we = 1'b0;
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("rst_async_rd1", rd1, 32'd0);
    read_all("rst_all");
    // a write pending while reset is held is lost
    we = 1'b1; wa = 5'd10; wd = 32'hcafef00d;
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd5);
    rst_n = 1'b1;
    step();
    chk("rst_lost_wr", rd1, 32'd0);

    // 2. basic writes
    drive(1'b1, 5'd1, 32'd1, 5'd1, 5'd2);            step(); chk("wr_r1", rd1, 32'd1);
    drive(1'b1, 5'd8, 32'h65465666, 5'd8, 5'd2);     step(); chk("wr_r8", rd1, 32'h65465666);
    drive(1'b1, 5'd31, 32'hfffffffa, 5'd31, 5'd2);   step(); chk("wr_r31", rd1, 32'hfffffffa);
    we = 1'b0;
    for (int i = 2; i <= 7; i++) begin
      ra1 = 5'(i); #1;
      chk("r2_r7_zero", rd1, 32'd0);
    end

    // 3. register zero
    drive(1'b1, 5'd0, 32'hdeadbeef, 5'd0, 5'd0);
    chk("r0_pre", rd1, 32'd0);
    step();
    chk("r0_post", rd1, 32'd0);

    // 4. same-address hazard
    drive(1'b1, 5'd9, 32'd7, 5'd1, 5'd1); step();
    drive(1'b1, 5'd9, 32'd42, 5'd9, 5'd9);
    chk("haz_pre_rd1", rd1, BYP ? 32'd42 : 32'd7);
    chk("haz_pre_rd2", rd2, BYP ? 32'd42 : 32'd7);
    step();
    chk("haz_post_rd1", rd1, 32'd42);
    chk("haz_post_rd2", rd2, 32'd42);

    // 5. we=0 hold and dual port
    drive(1'b0, 5'd3, 32'd99, 5'd3, 5'd3); step();
    chk("hold_r3", rd1, 32'd0);
    drive(1'b0, 5'd3, 32'd99, 5'd1, 5'd31);
    chk("dual_rd1", rd1, 32'd1);
    chk("dual_rd2", rd2, 32'hfffffffa);

    // 6. sweep
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i * 3), 5'd0, 5'd0);
      step();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i); #1;
      chk("sweep_rd1", rd1, (i == 0) ? 32'd0 : 32'(i * 3));
      chk("sweep_rd2", rd2, (i == 0) ? 32'd0 : 32'(i * 3));
    end

    // random traffic, with frequent read-after-write address collisions
    for (int n = 0; n < 300; n++) begin
      logic [4:0] a, r1, r2;
      a  = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), a, $urandom, r1, r2);
      chk("rand_pre_rd1", rd1, exp_rd(ra1));
      chk("rand_pre_rd2", rd2, exp_rd(ra2));
      step();
      chk("rand_post_rd1", rd1, exp_rd(ra1));
      chk("rand_post_rd2", rd2, exp_rd(ra2));
    end

    we = 1'b0;
    read_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
